// File: rtl/mm2x2_sched_if.sv
// Handshake and array bundle for the 2x2 matrix-multiply scheduler.
// slave = scheduler side, master = requesters/array/consumer side.
interface mm2x2_sched_if;
  logic         in0_valid;
  logic         in0_ready;
  logic [63:0]  in0_data;
  logic         in1_valid;
  logic         in1_ready;
  logic [63:0]  in1_data;
  logic [63:0]  arr_opnd;
  logic         arr_en;
  logic [127:0] arr_prod;
  logic         out_valid;
  logic         out_ready;
  logic [67:0]  out_data;
  logic         out_id;

  modport slave (
    input  in0_valid, in0_data, in1_valid, in1_data, arr_prod, out_ready,
    output in0_ready, in1_ready, arr_opnd, arr_en, out_valid, out_data, out_id
  );

  modport master (
    output in0_valid, in0_data, in1_valid, in1_data, arr_prod, out_ready,
    input  in0_ready, in1_ready, arr_opnd, arr_en, out_valid, out_data, out_id
  );
endinterface

// File: rtl/mm2x2_sched.sv
// Round-robin scheduler for the shared 8-multiplier array; sums products into a credit-protected FIFO.
// Accept-to-out_valid is 2 cycles; requesters stall once FIFO plus in-flight entries reach DEPTH.
module mm2x2_sched #(
  parameter int DEPTH = 4
) (
  input logic          clk,
  input logic          rst,
  mm2x2_sched_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic          rr_ptr;
  logic          s1_v;
  logic          s1_id;
  logic [CW-1:0] count;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [67:0]   mem_data [DEPTH];
  logic          mem_id   [DEPTH];

  logic          can_issue;
  logic          gnt0;
  logic          gnt1;
  logic          issue;
  logic          push;
  logic          pop;
  logic [CW:0]   used;
  logic [16:0]   r00, r01, r10, r11;

  // The in-flight stage-1 entry already owns a FIFO slot; a same-cycle pop is not counted.
  always_comb begin
    used      = {1'b0, count} + {{CW{1'b0}}, s1_v};
    can_issue = !rst && (used < DEPTH_W);
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    if (can_issue) begin
      if (bus.in0_valid && bus.in1_valid) begin
        gnt0 = !rr_ptr;
        gnt1 = rr_ptr;
      end else begin
        gnt0 = bus.in0_valid;
        gnt1 = bus.in1_valid;
      end
    end
  end

  assign issue         = gnt0 | gnt1;
  assign bus.in0_ready = gnt0;
  assign bus.in1_ready = gnt1;
  assign bus.arr_en    = issue;
  assign bus.arr_opnd  = gnt0 ? bus.in0_data : (gnt1 ? bus.in1_data : 64'd0);

  // Product order on arr_prod: AE, BG, CE, DG, AF, BH, CF, DH.
  always_comb begin
    r00 = {1'b0, bus.arr_prod[127:112]} + {1'b0, bus.arr_prod[111:96]};
    r10 = {1'b0, bus.arr_prod[95:80]}   + {1'b0, bus.arr_prod[79:64]};
    r01 = {1'b0, bus.arr_prod[63:48]}   + {1'b0, bus.arr_prod[47:32]};
    r11 = {1'b0, bus.arr_prod[31:16]}   + {1'b0, bus.arr_prod[15:0]};
  end

  assign push          = s1_v;
  assign bus.out_valid = (count != '0);
  assign pop           = bus.out_valid && bus.out_ready;
  assign bus.out_data  = bus.out_valid ? mem_data[rd_ptr] : 68'd0;
  assign bus.out_id    = bus.out_valid ? mem_id[rd_ptr] : 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= 1'b0;
      s1_v   <= 1'b0;
      s1_id  <= 1'b0;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      s1_v  <= issue;
      s1_id <= gnt1;
      if (issue) begin
        rr_ptr <= gnt0;
      end
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= {r00, r01, r10, r11};
      mem_id[wr_ptr]   <= s1_id;
    end
  end

  assert property (@(posedge clk) disable iff (rst) !(gnt0 && gnt1));
  assert property (@(posedge clk) disable iff (rst) !(push && !pop && count == DEPTH_C));
endmodule

// File: tb/tb_mm2x2_sched.sv
// Bench for mm2x2_sched: product-array model, table vectors, and a scoreboard fed at every grant.
module tb_mm2x2_sched;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  mm2x2_sched_if bus();

  mm2x2_sched #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [67:0] data;
    logic        id;
  } exp_t;

  typedef struct {
    logic        sel;
    logic [63:0] data;
    logic [16:0] r00, r01, r10, r11;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   pops   = 0;
  exp_t sb[$];
  exp_t mon_e;
  exp_t new_e;
  logic [127:0] prod_q = '0;
  vec_t tbl[5];

  function automatic logic [67:0] model(input logic [63:0] d);
    int a, b, c, e, f, g, h, dd;
    a = int'(d[63:56]); b = int'(d[55:48]); c = int'(d[47:40]); dd = int'(d[39:32]);
    e = int'(d[31:24]); f = int'(d[23:16]); g = int'(d[15:8]);  h  = int'(d[7:0]);
    return {17'(a*e + b*g), 17'(a*f + b*h), 17'(c*e + dd*g), 17'(c*f + dd*h)};
  endfunction

  function automatic logic [127:0] prods(input logic [63:0] d);
    int a, b, c, e, f, g, h, dd;
    a = int'(d[63:56]); b = int'(d[55:48]); c = int'(d[47:40]); dd = int'(d[39:32]);
    e = int'(d[31:24]); f = int'(d[23:16]); g = int'(d[15:8]);  h  = int'(d[7:0]);
    return {16'(a*e), 16'(b*g), 16'(c*e), 16'(dd*g), 16'(a*f), 16'(b*h), 16'(c*f), 16'(dd*h)};
  endfunction

  // Product array: captures on arr_en, products visible the following cycle.
  always @(posedge clk) begin
    if (bus.arr_en) prod_q <= prods(bus.arr_opnd);
  end
  assign bus.arr_prod = prod_q;

  task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((sb.size() != 0 || bus.out_valid) && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 60) begin
      errors++;
      $display("FAIL %s: drain timeout, %0d pending, expected 0", name, sb.size());
    end
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    bus.in0_valid = 1'b0;
    bus.in1_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Monitor: pop before push since an accepted item cannot reach the head in the same cycle.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got out_data %0h id %0d, expected no output", bus.out_data, bus.out_id);
        end else begin
          mon_e = sb.pop_front();
          chk("sb_data", bus.out_data, mon_e.data);
          chk("sb_id", 68'(bus.out_id), 68'(mon_e.id));
          pops++;
        end
      end
      if (bus.in0_valid && bus.in1_valid)
        chk("one_ready", 68'(bus.in0_ready & bus.in1_ready), 68'd0);
      if (bus.in0_valid && bus.in0_ready) begin
        new_e.data = model(bus.in0_data);
        new_e.id   = 1'b0;
        sb.push_back(new_e);
      end
      if (bus.in1_valid && bus.in1_ready) begin
        new_e.data = model(bus.in1_data);
        new_e.id   = 1'b1;
        sb.push_back(new_e);
      end
      if (bus.in0_ready || bus.in1_ready)
        chk("credit", 68'(sb.size() > DEPTH), 68'd0);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int p0;
    int n;

    tbl[0] = '{1'b0, 64'h0102030405060708, 17'd19, 17'd22, 17'd43, 17'd50};
    tbl[1] = '{1'b1, 64'hFFFFFFFFFFFFFFFF, 17'd130050, 17'd130050, 17'd130050, 17'd130050};
    tbl[2] = '{1'b0, 64'h0000000000000000, 17'd0, 17'd0, 17'd0, 17'd0};
    tbl[3] = '{1'b1, 64'h0100000109080706, 17'd9, 17'd8, 17'd7, 17'd6};
    tbl[4] = '{1'b0, 64'hFF01028010FFFF03, 17'd4335, 17'd65028, 17'd32672, 17'd894};

    bus.in0_valid = 1'b1;
    bus.in1_valid = 1'b0;
    bus.in0_data  = 64'h0102030405060708;
    bus.in1_data  = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("rst_in0_ready", 68'(bus.in0_ready), 68'd0);
    chk("rst_arr_en", 68'(bus.arr_en), 68'd0);
    chk("rst_arr_opnd", 68'(bus.arr_opnd), 68'd0);
    chk("rst_out_valid", 68'(bus.out_valid), 68'd0);
    chk("rst_out_data", bus.out_data, 68'd0);
    chk("rst_out_id", 68'(bus.out_id), 68'd0);
    tick();
    bus.in0_valid = 1'b0;
    rst = 1'b0;
    bus.out_ready = 1'b1;

    for (int i = 0; i < 5; i++) begin
      tick();
      bus.in0_valid = !tbl[i].sel;
      bus.in1_valid = tbl[i].sel;
      bus.in0_data  = tbl[i].data;
      bus.in1_data  = tbl[i].data;
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", i), 68'(tbl[i].sel ? bus.in1_ready : bus.in0_ready), 68'd1);
      chk($sformatf("tbl%0d_arr_opnd", i), 68'(bus.arr_opnd), 68'(tbl[i].data));
      tick();
      bus.in0_valid = 1'b0;
      bus.in1_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("tbl%0d_lat1_valid", i), 68'(bus.out_valid), 68'd0);
      @(negedge clk);
      chk($sformatf("tbl%0d_lat2_valid", i), 68'(bus.out_valid), 68'd1);
      chk($sformatf("tbl%0d_data", i), bus.out_data, {tbl[i].r00, tbl[i].r01, tbl[i].r10, tbl[i].r11});
      chk($sformatf("tbl%0d_id", i), 68'(bus.out_id), 68'(tbl[i].sel));
    end
    drain("tbl_drain");

    // Alternating grants from a fresh reset.
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      bus.in0_valid = 1'b1;
      bus.in1_valid = 1'b1;
      bus.in0_data  = {$urandom, $urandom};
      bus.in1_data  = {$urandom, $urandom};
      @(negedge clk);
      chk($sformatf("rr%0d_in0_ready", i), 68'(bus.in0_ready), 68'(i % 2 == 0));
      chk($sformatf("rr%0d_in1_ready", i), 68'(bus.in1_ready), 68'(i % 2 == 1));
    end
    tick();
    bus.in0_valid = 1'b0;
    bus.in1_valid = 1'b0;
    drain("rr_drain");

    // Backpressure: exactly DEPTH accepts with the consumer stalled.
    bus.out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      bus.in0_valid = 1'b1;
      bus.in0_data  = {$urandom, $urandom};
      @(negedge clk);
      if (bus.in0_ready) acc++;
    end
    chk("bp_accepts", 68'(acc), 68'(DEPTH));
    chk("bp_stalled", 68'(bus.in0_ready), 68'd0);
    tick();
    bus.out_ready = 1'b1;
    p0 = pops;
    n = 0;
    @(negedge clk);
    while (!bus.in0_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("bp_resume", 68'(bus.in0_ready), 68'd1);
    tick();
    bus.in0_valid = 1'b0;
    drain("bp_drain");
    chk("bp_pops", 68'(pops - p0 >= DEPTH), 68'd1);

    // Random traffic: mixed push/pop near full and many pointer wraps.
    p0 = pops;
    for (int i = 0; i < 200; i++) begin
      tick();
      bus.in0_valid = 1'($urandom_range(0, 1));
      bus.in1_valid = 1'($urandom_range(0, 1));
      bus.in0_data  = {$urandom, $urandom};
      bus.in1_data  = {$urandom, $urandom};
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end
    tick();
    bus.in0_valid = 1'b0;
    bus.in1_valid = 1'b0;
    bus.out_ready = 1'b1;
    drain("rand_drain");
    chk("rand_wraps", 68'(pops - p0 >= 3 * DEPTH), 68'd1);

    // Reset with two buffered entries and one in flight.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      bus.in0_valid = 1'b1;
      bus.in0_data  = {$urandom, $urandom};
      @(negedge clk);
    end
    tick();
    bus.in0_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("prerst_buffered", 68'(bus.out_valid), 68'd1);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("postrst_out_valid", 68'(bus.out_valid), 68'd0);
    chk("postrst_out_data", bus.out_data, 68'd0);
    chk("postrst_out_id", 68'(bus.out_id), 68'd0);
    tick();
    bus.out_ready = 1'b1;
    bus.in0_valid = 1'b1;
    bus.in1_valid = 1'b1;
    bus.in0_data  = 64'h0102030405060708;
    bus.in1_data  = 64'hFFFFFFFFFFFFFFFF;
    @(negedge clk);
    chk("postrst_rr_in0", 68'(bus.in0_ready), 68'd1);
    chk("postrst_rr_in1", 68'(bus.in1_ready), 68'd0);
    tick();
    bus.in0_valid = 1'b0;
    bus.in1_valid = 1'b0;
    drain("rst_drain");
    repeat (4) @(negedge clk);
    chk("final_idle", 68'(bus.out_valid), 68'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mm2x2_sched.md
Name: mm2x2_sched

Overview:
- Arbitrates two requesters onto the shared 8-multiplier product array of the 2x2 matrix multiplier, one matrix pair per cycle.
- Drives operands and the capture enable into the array, then sums the registered products into the four result entries.
- Tags each result with its requester ID and buffers results in a credit-protected output FIFO with a valid/ready interface.

Parameters:
- DEPTH, 4, output FIFO entries (power of 2, >=2)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in0_valid  in  1  requester 0 has an operand pair
- in0_ready  out  1  requester 0 accepted this cycle when in0_valid also high
- in0_data  in  64  {A,B,C,D,E,F,G,H}, A at [63:56], H at [7:0]; X=[[A,B],[C,D]], Y=[[E,F],[G,H]]
- in1_valid, in1_ready, in1_data  same as requester 0, for requester 1
- arr_opnd  out  64  operands to the array, same packing as in*_data
- arr_en  out  1  array captures all 8 products on this clk edge
- arr_prod  in  128  {AE,BG,CE,DG,AF,BH,CF,DH}, 16 b each, AE at [127:112]; valid the cycle after arr_en
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- out_data  out  68  {R00,R01,R10,R11}, 17 b each, R00 at [67:51]
- out_id  out  1  requester ID of head entry

Behaviour:
- Reset values: in0_ready=in1_ready=0, arr_en=0, arr_opnd=0, out_valid=0, out_data=0, out_id=0. FIFO empty, stage-1 valid cleared, RR pointer = requester 0.
- Reset mid-operation discards all in-flight and buffered results. No output appears for transactions issued before reset.
- Credit:
  - can_issue = (fifo_count + s1_v) < DEPTH, where s1_v = issue occurred in the previous cycle.
  - A pop in the same cycle does not add credit (conservative).
- Arbitration (combinational, same cycle):
  - If can_issue and exactly one valid, grant that one.
  - If both valid, grant the RR pointer's requester.
  - in*_ready = grant for that requester. Never assert both readies.
  - After any grant, the pointer moves to the non-granted requester. With no grant, the pointer holds.
- Issue cycle N: arr_en=1, arr_opnd = granted data (combinational mux; 0 when no grant), and arr_en=0 when no grant. The requester ID is registered into stage 1 (s1_v, s1_id).
- Cycle N+1, when s1_v=1:
  - R00=AE+BG, R01=AF+BH, R10=CE+DG, R11=CF+DH, each zero-extended to 17 b with no truncation.
  - The sums and s1_id are written into the FIFO at the end of N+1.
- Cycle N+2: the entry is visible at the FIFO head (out_valid=1 if FIFO was empty). Minimum latency accept-to-out_valid is 2 cycles. Throughput is 1/cycle with out_ready=1.
- FIFO:
  - Pop when out_valid & out_ready. out_data/out_id are stable while out_valid=1 and not popped.
  - Simultaneous push and pop keeps the count unchanged.
  - Write is never blocked: credit guarantees space. Overflow is a design error (assert in bench).
  - Pointers wrap modulo DEPTH.
- Order: results leave in issue order regardless of requester.
- Inputs are sampled only on the grant cycle. A requester may change in*_data while not granted.

Test Plan:
- Single req0, X=[[1,2],[3,4]], Y=[[5,6],[7,8]] (in0_data=0x0102030405060708), out_ready=1 -> out_valid 2 cycles after accept, R00=19, R01=22, R10=43, R11=50, out_id=0.
- All operands 0xFF on req1 -> every entry 130050 (0x1FC02), out_id=1, no truncation.
- Both valid continuously for 6 cycles with out_ready=1 -> grants alternate 0,1,0,1,0,1 starting at 0 after reset. Outputs arrive in the same order at 1/cycle.
- out_ready=0, req0 streaming, DEPTH=4 -> exactly 4 accepts, then in0_ready=0 with no FIFO overflow. Raising out_ready drains 4 results in order and accepts resume.
- Push/pop same cycle with FIFO at DEPTH-1 -> count stable, no accept beyond credit, pointer wrap verified over 3×DEPTH transactions.
- Assert rst one cycle after an accept with 2 entries buffered -> all outputs reset next cycle, the in-flight result never appears, and the RR pointer returns to 0.
